// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between the host MCU (master) and the register slave.
// Mode 0, MSB first; ss is active high.
interface spi_reg_slave_if;
    logic sck;
    logic ss;
    logic si;
    logic so;

    modport master (output sck, output ss, output si, input so);
    modport slave  (input sck, input ss, input si, output so);
endinterface

// File: rtl/spi_reg_slave.sv
// Clocked SPI mode-0 slave decoding command/data bytes into a small register file.
// All SPI pins are oversampled through synchronisers; so is fully registered.
module spi_reg_slave #(
    parameter int NUM_REGS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_reg_slave_if.slave        spi,
    input  logic [7:0]            status_in,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_reg, ss_sync_reg, si_sync_reg;
    logic       sck_d_reg, ss_d_reg;
    state_t     state_reg;
    logic [2:0] bit_cnt_reg;
    logic [6:0] rx_shift_reg;
    logic [6:0] tx_rest_reg;
    logic [6:0] addr_reg;
    logic       is_write_reg;
    logic [7:0] regs [NUM_REGS];

    logic       sck_s, ss_s, si_s;
    logic       sck_rise, sck_fall, ss_rise, byte_done;
    logic [7:0] rx_byte;
    logic [6:0] rd_addr;
    logic [7:0] rd_val;

    assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
    assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
    assign si_s      = si_sync_reg[SYNC_STAGES-1];
    assign sck_rise  = sck_s & ~sck_d_reg;
    assign sck_fall  = ~sck_s & sck_d_reg;
    assign ss_rise   = ss_s & ~ss_d_reg;
    assign byte_done = sck_rise && (bit_cnt_reg == 3'd7) && (state_reg != IDLE);
    assign rx_byte   = {rx_shift_reg, si_s};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            assign reg_out[8*gi +: 8] = regs[gi];
        end
    endgenerate

    // The command byte addresses the first read; data bytes pre-fetch the next address.
    always_comb begin
        rd_addr = (state_reg == CMD) ? rx_byte[6:0] : addr_reg + 7'd1;
        rd_val  = 8'h00;
        if (rd_addr == 7'h7F)
            rd_val = status_in;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr == 7'(i))
                rd_val = regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_reg <= '0;
            ss_sync_reg  <= '0;
            si_sync_reg  <= '0;
            sck_d_reg    <= 1'b0;
            ss_d_reg     <= 1'b0;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], spi.sck};
            ss_sync_reg  <= {ss_sync_reg[SYNC_STAGES-2:0], spi.ss};
            si_sync_reg  <= {si_sync_reg[SYNC_STAGES-2:0], spi.si};
            sck_d_reg    <= sck_s;
            ss_d_reg     <= ss_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            rx_shift_reg <= 7'd0;
            tx_rest_reg  <= 7'd0;
            addr_reg     <= 7'd0;
            is_write_reg <= 1'b0;
            spi.so       <= 1'b0;
            wr_strobe    <= 1'b0;
            wr_addr      <= 7'd0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (!ss_s) begin
                bit_cnt_reg <= 3'd0;
            end else if (sck_rise) begin
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                rx_shift_reg <= {rx_shift_reg[5:0], si_s};
            end

            case (state_reg)
                IDLE: begin
                    spi.so      <= 1'b0;
                    tx_rest_reg <= 7'd0;
                    if (ss_rise)
                        state_reg <= CMD;
                end
                CMD: begin
                    if (byte_done) begin
                        is_write_reg <= rx_byte[7];
                        addr_reg     <= rx_byte[6:0];
                        state_reg    <= DATA;
                        if (rx_byte[7]) begin
                            tx_rest_reg <= 7'd0;
                            spi.so      <= 1'b0;
                        end else begin
                            tx_rest_reg <= rd_val[6:0];
                            spi.so      <= rd_val[7];
                        end
                    end
                end
                DATA: begin
                    if (byte_done) begin
                        if (is_write_reg) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_reg == 7'(i)) begin
                                    regs[i]   <= rx_byte;
                                    wr_strobe <= 1'b1;
                                    wr_addr   <= addr_reg;
                                end
                            end
                        end else begin
                            tx_rest_reg <= rd_val[6:0];
                            spi.so      <= rd_val[7];
                        end
                        addr_reg <= addr_reg + 7'd1;
                    end else if (sck_fall && bit_cnt_reg != 3'd0) begin
                        // The fall right after a byte boundary must keep the freshly loaded MSB.
                        spi.so      <= tx_rest_reg[6];
                        tx_rest_reg <= {tx_rest_reg[5:0], 1'b0};
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (!ss_s && state_reg != IDLE) begin
                state_reg   <= IDLE;
                spi.so      <= 1'b0;
                tx_rest_reg <= 7'd0;
            end
        end
    end
endmodule
